// File: rtl/sr_seq_pkg.sv
// -----------------------------------------------------------------------------
// sr_seq_pkg
// Shared types and constants for the SR-latch sequencer.
//   state_t  : controller states (IDLE, PULSE, SETTLE, ACK)
//   OP_SET   : op value that sets the latch (Q=1)
//   OP_CLR   : op value that clears the latch (Q=0)
//   CNT_W    : width of the pulse/settle down-counter
//   rr_pick  : round-robin choice between the two requesters
// -----------------------------------------------------------------------------
package sr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    SETTLE = 2'd2,
    ACK    = 2'd3
  } state_t;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;
  localparam int   CNT_W  = 4;

  // A lone requester always wins; on a tie the one not granted last wins.
  // The 2'b00 case is never consulted (caller only picks when |req).
  function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
    logic pick;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      default: pick = ~last_grant;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/sr_latch_sequencer_sync2.sv
// -----------------------------------------------------------------------------
// sr_sync2
// Two-flop synchronizer for one asynchronous feedback bit from the latch cell.
//   clk : sampling clock
//   rst : synchronous, active-high reset; both stages clear to 0
//   i_d : asynchronous input
//   o_q : synchronized output, two clk edges behind i_d
// -----------------------------------------------------------------------------
module sr_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sr_latch_sequencer.sv
// -----------------------------------------------------------------------------
// sr_latch_sequencer
// Shares one cross-coupled NAND SR latch between two requesters. Grants
// round-robin, drives a single active-low lane for PULSE_CYCLES, then waits
// up to SETTLE_MAX cycles for synchronized Q/Qnot to confirm the new state
// and acknowledges with ok/timeout.
//   clk, rst          : clock, synchronous active-high reset
//   req[1:0]          : per-requester level request, held until ack
//   op[1:0]           : 1 = set latch, 0 = clear latch; sampled at grant
//   ack[1:0]          : one-cycle acknowledge to the granted requester
//   err               : valid with ack; 1 = settle timeout
//   fault             : sticky timeout flag, cleared only by rst
//   busy              : high in every state except IDLE
//   s0_n, s1_n        : active-low set lanes (requester 0 / 1)
//   r0_n, r1_n        : active-low reset lanes (requester 0 / 1)
//   q, qnot           : asynchronous latch outputs
// -----------------------------------------------------------------------------
module sr_latch_sequencer
  import sr_seq_pkg::*;
#(
  parameter int PULSE_CYCLES = 3,   // legal 2..15
  parameter int SETTLE_MAX   = 8    // legal 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] op,
  output logic [1:0] ack,
  output logic       err,
  output logic       fault,
  output logic       busy,
  output logic       s0_n,
  output logic       s1_n,
  output logic       r0_n,
  output logic       r1_n,
  input  logic       q,
  input  logic       qnot
);

  localparam logic [CNT_W-1:0] L_PULSE  = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] L_SETTLE = CNT_W'(SETTLE_MAX);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_grant;
  logic             r_op;
  logic             r_last_grant;
  logic [1:0]       r_ack;
  logic             r_err;
  logic             r_fault;
  logic             r_busy;
  logic [1:0]       r_s_n;
  logic [1:0]       r_r_n;

  logic w_q_s;
  logic w_qnot_s;
  logic w_match;
  logic w_pick;

  sr_sync2 u_sync_q (
    .clk (clk),
    .rst (rst),
    .i_d (q),
    .o_q (w_q_s)
  );

  sr_sync2 u_sync_qnot (
    .clk (clk),
    .rst (rst),
    .i_d (qnot),
    .o_q (w_qnot_s)
  );

  assign w_pick  = rr_pick(req, r_last_grant);
  assign w_match = (w_q_s == r_op) && (w_qnot_s == ~r_op);

  // NOTE: every output below is a flop, so lanes and ack/err/busy never
  // glitch from req; all state uses non-blocking assignment so each
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_grant      <= 1'b0;
      r_op         <= OP_CLR;
      r_last_grant <= 1'b1;
      r_ack        <= 2'b00;
      r_err        <= 1'b0;
      r_fault      <= 1'b0;
      r_busy       <= 1'b0;
      r_s_n        <= 2'b11;
      r_r_n        <= 2'b11;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (|req) begin
            r_grant <= w_pick;
            r_op    <= op[w_pick];
            r_cnt   <= L_PULSE;
            r_busy  <= 1'b1;
            // Exactly one lane goes low: set or reset, never both.
            if (op[w_pick] == OP_SET) r_s_n[w_pick] <= 1'b0;
            else                      r_r_n[w_pick] <= 1'b0;
            r_state <= PULSE;
          end
        end

        PULSE: begin
          // Releasing on count 1 means the decrement-to-zero edge is the
          // release edge, giving exactly PULSE_CYCLES low cycles.
          if (r_cnt == CNT_W'(1)) begin
            r_s_n   <= 2'b11;
            r_r_n   <= 2'b11;
            r_cnt   <= L_SETTLE;
            r_state <= SETTLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        SETTLE: begin
          if (w_match) begin
            r_ack[r_grant] <= 1'b1;
            r_err          <= 1'b0;
            r_state        <= ACK;
          end else if (r_cnt == CNT_W'(1)) begin
            r_ack[r_grant] <= 1'b1;
            r_err          <= 1'b1;
            r_fault        <= 1'b1;
            r_state        <= ACK;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        ACK: begin
          r_ack        <= 2'b00;
          r_err        <= 1'b0;
          r_busy       <= 1'b0;
          r_last_grant <= r_grant;
          r_state      <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack   = r_ack;
  assign err   = r_err;
  assign fault = r_fault;
  assign busy  = r_busy;
  assign s0_n  = r_s_n[0];
  assign s1_n  = r_s_n[1];
  assign r0_n  = r_r_n[0];
  assign r1_n  = r_r_n[1];

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sr_latch_sequencer
// Directed bench for sr_latch_sequencer with a behavioural NAND-latch model
// that responds within one cycle (or is held stuck at Q=0 for timeouts).
// Lane vector order used throughout: {r1_n, r0_n, s1_n, s0_n}.
// -----------------------------------------------------------------------------
module tb_sr_latch_sequencer;

  localparam int PULSE  = 3;
  localparam int SETTLE = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] op  = 2'b00;
  logic [1:0] ack;
  logic       err;
  logic       fault;
  logic       busy;
  logic       s0_n, s1_n, r0_n, r1_n;
  logic       q, qnot;

  logic       lq    = 1'b0;   // latch model state
  logic       stuck = 1'b0;   // force Q=0 / Qnot=1
  logic [3:0] lanes;

  int checks     = 0;
  int failures   = 0;
  int lane_viol  = 0;

  assign lanes = {r1_n, r0_n, s1_n, s0_n};
  assign q     = stuck ? 1'b0 : lq;
  assign qnot  = ~q;

  sr_latch_sequencer #(
    .PULSE_CYCLES (PULSE),
    .SETTLE_MAX   (SETTLE)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .op    (op),
    .ack   (ack),
    .err   (err),
    .fault (fault),
    .busy  (busy),
    .s0_n  (s0_n),
    .s1_n  (s1_n),
    .r0_n  (r0_n),
    .r1_n  (r1_n),
    .q     (q),
    .qnot  (qnot)
  );

  always #5 clk = ~clk;

  // Latch reacts half a cycle after the lanes move; also watch exclusivity.
  always @(negedge clk) begin
    if (!(s0_n & s1_n))      lq = 1'b1;
    else if (!(r0_n & r1_n)) lq = 1'b0;
    if ($countones(~lanes) > 1) lane_viol = lane_viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic exp_fault);
    check({tag, "_lanes"}, 32'(lanes), 32'hF);
    check({tag, "_ack"},   32'(ack),   32'h0);
    check({tag, "_busy"},  32'(busy),  32'h0);
    check({tag, "_fault"}, 32'(fault), 32'(exp_fault));
  endtask

  // Caller has set req/op; the next edge is E0. Checks every cycle through
  // the ack edge, applies next_req, then checks the return to IDLE.
  task automatic do_txn(input string tag, input logic [3:0] exp_lanes,
                        input logic [1:0] exp_ack, input logic exp_err,
                        input int ack_edge, input logic fault_pre,
                        input logic drop, input logic [1:0] next_req);
    for (int e = 0; e <= ack_edge; e++) begin
      tick();
      if (drop && e == 0) req = 2'b00;
      check({tag, "_lanes"}, 32'(lanes), (e < PULSE) ? 32'(exp_lanes) : 32'hF);
      check({tag, "_busy"},  32'(busy),  32'h1);
      check({tag, "_ack"},   32'(ack),   (e == ack_edge) ? 32'(exp_ack) : 32'h0);
      check({tag, "_fault"}, 32'(fault),
            (e == ack_edge) ? 32'(fault_pre | exp_err) : 32'(fault_pre));
      if (e == ack_edge) check({tag, "_err"}, 32'(err), 32'(exp_err));
    end
    req = next_req;
    tick();
    check_idle({tag, "_done"}, fault_pre | exp_err);
  endtask

  initial begin
    // Reset and idle
    rst = 1'b1;
    req = 2'b00;
    repeat (3) tick();
    check_idle("in_rst", 1'b0);
    rst = 1'b0;
    tick();
    check_idle("post_rst", 1'b0);
    check("post_rst_err", 32'(err), 32'h0);

    // Single set by requester 0, held through ACK for a re-grant that
    // targets the state the latch already holds.
    req = 2'b01;
    op  = 2'b01;
    do_txn("set0", 4'hE, 2'b01, 1'b0, PULSE + 1, 1'b0, 1'b0, 2'b01);
    check("set0_q", 32'(q), 32'h1);
    do_txn("held0", 4'hE, 2'b01, 1'b0, PULSE + 1, 1'b0, 1'b0, 2'b00);
    check("held0_q", 32'(q), 32'h1);

    // Timeout: latch stuck at Q=0, requester 1 asks to set.
    stuck = 1'b1;
    req   = 2'b10;
    op    = 2'b10;
    do_txn("tmo", 4'hD, 2'b10, 1'b1, PULSE + SETTLE, 1'b0, 1'b0, 2'b00);
    stuck = 1'b0;

    // Dropped request: requester 1 clears, req high for one cycle only.
    req = 2'b10;
    op  = 2'b00;
    do_txn("drop", 4'h7, 2'b10, 1'b0, PULSE + 1, 1'b1, 1'b1, 2'b00);
    check("drop_q", 32'(q), 32'h0);

    // Make requester 0 the last grant, then reset during requester 1's
    // second pulse cycle.
    req = 2'b01;
    op  = 2'b00;
    do_txn("clr0", 4'hB, 2'b01, 1'b0, PULSE + 1, 1'b1, 1'b0, 2'b00);
    req = 2'b10;
    op  = 2'b10;
    tick();
    check("mid_p1_lanes", 32'(lanes), 32'hD);
    check("mid_p1_busy",  32'(busy),  32'h1);
    tick();
    check("mid_p2_lanes", 32'(lanes), 32'hD);
    rst = 1'b1;
    req = 2'b00;
    tick();
    check_idle("mid_rst", 1'b0);
    check("mid_rst_err", 32'(err), 32'h0);
    rst = 1'b0;
    req = 2'b11;
    op  = 2'b01;
    do_txn("rst_tie", 4'hE, 2'b01, 1'b0, PULSE + 1, 1'b0, 1'b0, 2'b00);

    // Contention from reset: clear by requester 0, then set by requester 1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 2'b11;
    op  = 2'b10;
    do_txn("cont0", 4'hB, 2'b01, 1'b0, PULSE + 1, 1'b0, 1'b0, 2'b10);
    check("cont0_q", 32'(q), 32'h0);
    do_txn("cont1", 4'hD, 2'b10, 1'b0, PULSE + 1, 1'b0, 1'b0, 2'b00);
    check("cont1_q", 32'(q), 32'h1);

    check("lane_excl", 32'(lane_viol), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
